// File: rtl/mdu_seq_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO; 1 bit per cycle shift-add / restoring divide.
// Optional MDU_EARLY_EXIT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module mdu_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

`ifdef MDU_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      opb_q, opb_d;
  logic [WIDTH-1:0]   mpl_q, mpl_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_arith;
  logic               is_mdu;
  logic               signed_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [PW-1:0]      prod;

  // Function decode and operand magnitudes for signed ops
  assign is_arith  = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);
  assign is_mdu    = is_arith || (func == F_MFHI) || (func == F_MTHI) ||
                     (func == F_MFLO) || (func == F_MTLO);
  assign signed_op = (func == F_MULT) || (func == F_DIV);
  assign abs_a     = (signed_op && rs[WIDTH-1]) ? (~rs + WIDTH'(1)) : rs;
  assign abs_b     = (signed_op && rt[WIDTH-1]) ? (~rt + WIDTH'(1)) : rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      mpl_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      mpl_q     <= mpl_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    mpl_d     = mpl_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    rem_sh    = '0;
    diff      = '0;
    quo       = '0;
    rem       = '0;
    prod      = '0;

    case (state_q)
      S_IDLE: begin
        if (start && is_arith) begin
          is_div_d  = func[1];
          neg_d     = signed_op && (rs[WIDTH-1] ^ rt[WIDTH-1]);
          rem_neg_d = signed_op && rs[WIDTH-1];
          dz_d      = (rt == '0);
          cnt_d     = CNT_W'(WIDTH - 1);
          if (func[1]) begin
            // Divide: {remainder, quotient} pair starts as {0, dividend}
            acc_d = {{WIDTH{1'b0}}, abs_a};
            opb_d = {{WIDTH{1'b0}}, abs_b};
            mpl_d = '0;
          end else begin
            acc_d = '0;
            opb_d = {{WIDTH{1'b0}}, abs_a};
            mpl_d = abs_b;
          end
          state_d = S_CALC;
        end else if (start && (func == F_MTHI)) begin
          hi_d = rs;
        end else if (start && (func == F_MTLO)) begin
          lo_d = rs;
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          rem_sh = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
          diff   = rem_sh - {1'b0, opb_q[WIDTH-1:0]};
          if (!diff[WIDTH]) begin
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (mpl_q[0]) begin
            acc_d = acc_q + opb_q;
          end
          opb_d = opb_q << 1;
          mpl_d = mpl_q >> 1;
        end
        if ((cnt_q == '0) || (EARLY_EXIT && !is_div_q && ((mpl_q >> 1) == '0))) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          quo  = acc_q[WIDTH-1:0];
          rem  = acc_q[PW-1:WIDTH];
          // Divide by zero keeps the all-ones quotient regardless of signs
          lo_d = dz_q ? '1 : (neg_q ? (~quo + WIDTH'(1)) : quo);
          hi_d = rem_neg_q ? (~rem + WIDTH'(1)) : rem;
        end else begin
          prod = neg_q ? (~acc_q + PW'(1)) : acc_q;
          hi_d = prod[PW-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign stall   = start && busy && is_mdu;
  assign mf_data = (func == F_MFHI) ? hi_q : ((func == F_MFLO) ? lo_q : '0);

endmodule
